vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16: horizontal front porch, in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync pulse width, in clocks.
REQ-004 SHALL have parameter H_BACK, default 48: horizontal back porch, in clocks.
REQ-005 SHALL have parameters V_ACTIVE 480, V_FRONT 10, V_SYNC 2, V_BACK 33: vertical equivalents, in lines.
REQ-006 SHALL have parameter SYNC_POL, default 0: asserted level of hsync/vsync (0 = active-low).
REQ-007 SHALL have port clk, input, 1: pixel clock, the only clock.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port h_sync, output, 1: horizontal sync.
REQ-010 SHALL have port v_sync, output, 1: vertical sync; this is the frame clock consumed by downstream overlay blocks.
REQ-011 SHALL have port display_on, output, 1: high while the current pixel is visible.
REQ-012 SHALL have port pix_x, output, 10: horizontal counter.
REQ-013 SHALL have port pix_y, output, 10: vertical counter.
REQ-014 SHALL have port line_start, output, 1: one-clock strobe on the first pixel of each line.
REQ-015 SHALL have port frame_start, output, 1: one-clock strobe on the first pixel of each frame.
REQ-016 SHALL have port frame_count, output, 8: number of completed frames, modulo 256.

Function
REQ-017 pix_x SHALL increment by 1 every clk and wrap from H_TOTAL-1 (799) to 0, where H_TOTAL is the sum of the four H parameters.
REQ-018 pix_y SHALL increment by 1 only in a cycle where pix_x wraps, and SHALL wrap from V_TOTAL-1 (524) to 0.
REQ-019 Each axis SHALL carry a phase FSM ACTIVE->FRONT->SYNC->BACK->ACTIVE, with each transition taken when that axis counter crosses the corresponding boundary.
REQ-020 h_sync SHALL equal SYNC_POL exactly when pix_x is in [656,751], and SHALL equal ~SYNC_POL otherwise.
REQ-021 v_sync SHALL equal SYNC_POL exactly when pix_y is in [490,491], and SHALL equal ~SYNC_POL otherwise.
REQ-022 display_on SHALL be 1 exactly when pix_x<640 and pix_y<480.
REQ-023 All outputs SHALL be registers, computed from next-state counter values, so every output is aligned to the pix_x/pix_y presented in the same cycle (zero relative latency, glitch-free).
REQ-024 line_start SHALL be 1 in every cycle where pix_x==0, except the first cycle after reset.
REQ-025 frame_start SHALL be 1 only in the cycle entered by the wrap (799,524)->(0,0).
REQ-026 frame_count SHALL increment on the same edge that raises frame_start, and SHALL wrap 255->0.

Reset
REQ-027 On rst_n low, all state SHALL clear asynchronously: pix_x=0, pix_y=0, frame_count=0, line_start=0, frame_start=0, display_on=0, h_sync=v_sync=~SYNC_POL, both FSMs in ACTIVE.
REQ-028 The first clk edge after rst_n release SHALL give pix_x=1, display_on=1.
REQ-029 A reset asserted mid-frame SHALL discard the current frame with no partial strobe.

Structure
REQ-030 A shared package vga_timing_pkg SHALL hold the 640x480 timing constants, H_TOTAL/V_TOTAL, and the phase enum {ACTIVE,FRONT,SYNC,BACK}.
REQ-031 A sub-module sync_axis_counter (inputs en and timing parameters; outputs count, wrap, phase, sync, active) SHALL be instantiated twice, horizontal with en=1 and vertical with en=h wrap.

Verification
REQ-032 Release reset, run 800 clks: h_sync low for exactly pix_x 656..751, line_start high at clk 800 only, display_on low from pix_x 640.
REQ-033 Run 420000 clks (one frame): v_sync low for exactly 1600 clks at pix_y 490..491, frame_start pulses once at the wrap, frame_count=1.
REQ-034 Run 256 frames: frame_count wraps to 0 on the 256th frame_start.
REQ-035 Assert rst_n at (pix_x=300, pix_y=200) for 3 clks: all outputs reach reset values immediately, no frame_start is emitted, and counting restarts per REQ-028.
REQ-036 Set SYNC_POL=1: h_sync/v_sync invert, and all other outputs are cycle-identical to the default-parameter run.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA timing generator.
// Holds the 640x480@60 line/frame geometry, the derived totals, and the
// per-axis phase enum used by both axis counters.
package vga_timing_pkg;

  localparam int unsigned CNT_W       = 10;
  localparam int unsigned FRAME_CNT_W = 8;

  localparam int unsigned H_ACTIVE_640 = 640;
  localparam int unsigned H_FRONT_640  = 16;
  localparam int unsigned H_SYNC_640   = 96;
  localparam int unsigned H_BACK_640   = 48;
  localparam int unsigned H_TOTAL      = H_ACTIVE_640 + H_FRONT_640 + H_SYNC_640 + H_BACK_640;

  localparam int unsigned V_ACTIVE_480 = 480;
  localparam int unsigned V_FRONT_480  = 10;
  localparam int unsigned V_SYNC_480   = 2;
  localparam int unsigned V_BACK_480   = 33;
  localparam int unsigned V_TOTAL      = V_ACTIVE_480 + V_FRONT_480 + V_SYNC_480 + V_BACK_480;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

endpackage

// File: rtl/vga_timing_gen_sync_axis_counter.sv
// One axis (horizontal or vertical) of the raster: counter, phase FSM, sync.
// Latency: count/phase/sync are registered from next-state values; wrap and
// active are combinational (wrap = "this cycle ends the axis", active = next-state visibility).
// Ports: en advances the axis; count, wrap, phase, sync, active as above.
module sync_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_LEN = H_ACTIVE_640,
  parameter int unsigned FRONT_LEN  = H_FRONT_640,
  parameter int unsigned SYNC_LEN   = H_SYNC_640,
  parameter int unsigned BACK_LEN   = H_BACK_640,
  parameter logic        SYNC_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output phase_e           phase,
  output logic             sync,
  output logic             active
);

  localparam int unsigned      TOTAL       = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
  localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(ACTIVE_LEN);
  localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(ACTIVE_LEN + FRONT_LEN);
  localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);

  logic [CNT_W-1:0] count_q, count_d;
  phase_e           phase_q, phase_d;
  logic             sync_q, sync_d;

  always_comb begin
    wrap    = en && (count_q == LAST);
    count_d = count_q;
    phase_d = phase_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + 1'b1;
      // Phase follows the counter value being entered, so the registered
      // phase always matches the registered count.
      unique case (phase_q)
        PH_ACTIVE: if (count_d == FRONT_START) phase_d = PH_FRONT;
        PH_FRONT:  if (count_d == SYNC_START)  phase_d = PH_SYNC;
        PH_SYNC:   if (count_d == BACK_START)  phase_d = PH_BACK;
        PH_BACK:   if (wrap)                   phase_d = PH_ACTIVE;
        default:                               phase_d = PH_ACTIVE;
      endcase
    end
    sync_d = (phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    active = (phase_d == PH_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      phase_q <= PH_ACTIVE;
      sync_q  <= ~SYNC_POL;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign phase = phase_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, syncs, visibility, line/frame strobes.
// Latency: every output is a register loaded from next-state counts, so all
// outputs line up with the pix_x/pix_y shown in the same cycle. No backpressure.
// Ports: clk/rst_n in; h_sync, v_sync, display_on, pix_x, pix_y, line_start,
// frame_start, frame_count out.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_640,
  parameter int unsigned H_FRONT  = H_FRONT_640,
  parameter int unsigned H_SYNC   = H_SYNC_640,
  parameter int unsigned H_BACK   = H_BACK_640,
  parameter int unsigned V_ACTIVE = V_ACTIVE_480,
  parameter int unsigned V_FRONT  = V_FRONT_480,
  parameter int unsigned V_SYNC   = V_SYNC_480,
  parameter int unsigned V_BACK   = V_BACK_480,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   display_on,
  output logic [CNT_W-1:0]       pix_x,
  output logic [CNT_W-1:0]       pix_y,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  logic   h_wrap, v_wrap;
  logic   h_active, v_active;
  phase_e h_phase, v_phase;

  sync_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE),
    .FRONT_LEN  (H_FRONT),
    .SYNC_LEN   (H_SYNC),
    .BACK_LEN   (H_BACK),
    .SYNC_POL   (SYNC_POL)
  ) u_h_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (1'b1),
    .count  (pix_x),
    .wrap   (h_wrap),
    .phase  (h_phase),
    .sync   (h_sync),
    .active (h_active)
  );

  // Vertical axis advances once per line, on the horizontal wrap.
  sync_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE),
    .FRONT_LEN  (V_FRONT),
    .SYNC_LEN   (V_SYNC),
    .BACK_LEN   (V_BACK),
    .SYNC_POL   (SYNC_POL)
  ) u_v_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (h_wrap),
    .count  (pix_y),
    .wrap   (v_wrap),
    .phase  (v_phase),
    .sync   (v_sync),
    .active (v_active)
  );

  logic                   line_start_q, line_start_d;
  logic                   frame_start_q, frame_start_d;
  logic                   display_on_q, display_on_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

  always_comb begin
    // Strobes are qualified by the back-porch phase so they can only fire
    // out of a genuine end-of-axis, never out of a partially counted line.
    line_start_d  = h_wrap && (h_phase == PH_BACK);
    frame_start_d = line_start_d && v_wrap && (v_phase == PH_BACK);
    display_on_d  = h_active && v_active;
    frame_count_d = frame_count_q + FRAME_CNT_W'(frame_start_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      display_on_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      display_on_q  <= display_on_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign display_on  = display_on_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance plus two reduced-geometry
// instances (active-low and active-high sync) checked every cycle against a
// coordinate-level reference model, with directed and random resets.
module tb_vga_timing_gen;

  // Reduced geometry so whole frames fit in a short run.
  localparam int SHA = 6, SHF = 2, SHS = 2, SHB = 2, SHT = 12;
  localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 2, SVT = 9;
  localparam int SFRAME = SHT * SVT;
  localparam int DHT = 800, DVT = 525;

  logic clk;
  logic rst_n;

  logic       d0_hs, d0_vs, d0_disp, d0_ls, d0_fs;
  logic [9:0] d0_px, d0_py;
  logic [7:0] d0_fc;
  logic       ds_hs, ds_vs, ds_disp, ds_ls, ds_fs;
  logic [9:0] ds_px, ds_py;
  logic [7:0] ds_fc;
  logic       dp_hs, dp_vs, dp_disp, dp_ls, dp_fs;
  logic [9:0] dp_px, dp_py;
  logic [7:0] dp_fc;

  vga_timing_gen u_d0 (
    .clk(clk), .rst_n(rst_n), .h_sync(d0_hs), .v_sync(d0_vs), .display_on(d0_disp),
    .pix_x(d0_px), .pix_y(d0_py), .line_start(d0_ls), .frame_start(d0_fs), .frame_count(d0_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_POL(1'b0)
  ) u_ds (
    .clk(clk), .rst_n(rst_n), .h_sync(ds_hs), .v_sync(ds_vs), .display_on(ds_disp),
    .pix_x(ds_px), .pix_y(ds_py), .line_start(ds_ls), .frame_start(ds_fs), .frame_count(ds_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_POL(1'b1)
  ) u_dp (
    .clk(clk), .rst_n(rst_n), .h_sync(dp_hs), .v_sync(dp_vs), .display_on(dp_disp),
    .pix_x(dp_px), .pix_y(dp_py), .line_start(dp_ls), .frame_start(dp_fs), .frame_count(dp_fc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: raster position and frame tally, advanced one pixel per edge.
  typedef struct {
    int x;
    int y;
    int fc;
    bit ls;
    bit fs;
    bit in_rst;
  } mstate_t;

  localparam mstate_t M_RST = '{x: 0, y: 0, fc: 0, ls: 1'b0, fs: 1'b0, in_rst: 1'b1};

  mstate_t m0, ms;
  int checks = 0;
  int errors = 0;

  function automatic mstate_t m_step(mstate_t s, int ht, int vt);
    mstate_t n;
    n.in_rst = 1'b0;
    n.x      = (s.x + 1) % ht;
    n.ls     = (s.x == ht - 1);
    n.y      = n.ls ? (s.y + 1) % vt : s.y;
    n.fs     = n.ls && (s.y == vt - 1);
    n.fc     = (s.fc + (n.fs ? 1 : 0)) % 256;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string n, input mstate_t m,
                         input int ha, input int hf, input int hs,
                         input int va, input int vf, input int vs, input logic pol,
                         input logic o_hs, input logic o_vs, input logic o_disp,
                         input logic [9:0] o_px, input logic [9:0] o_py,
                         input logic o_ls, input logic o_fs, input logic [7:0] o_fc);
    logic e_hs, e_vs, e_disp;
    e_hs   = (m.x >= ha + hf && m.x < ha + hf + hs) ? pol : ~pol;
    e_vs   = (m.y >= va + vf && m.y < va + vf + vs) ? pol : ~pol;
    e_disp = !m.in_rst && (m.x < ha) && (m.y < va);
    chk({n, ".pix_x"}, 32'(o_px), 32'(m.x));
    chk({n, ".pix_y"}, 32'(o_py), 32'(m.y));
    chk({n, ".h_sync"}, 32'(o_hs), 32'(e_hs));
    chk({n, ".v_sync"}, 32'(o_vs), 32'(e_vs));
    chk({n, ".display_on"}, 32'(o_disp), 32'(e_disp));
    chk({n, ".line_start"}, 32'(o_ls), 32'(m.ls));
    chk({n, ".frame_start"}, 32'(o_fs), 32'(m.fs));
    chk({n, ".frame_count"}, 32'(o_fc), 32'(m.fc));
  endtask

  task automatic check_all();
    chk_dut("d0", m0, 640, 16, 96, 480, 10, 2, 1'b0,
            d0_hs, d0_vs, d0_disp, d0_px, d0_py, d0_ls, d0_fs, d0_fc);
    chk_dut("ds", ms, SHA, SHF, SHS, SVA, SVF, SVS, 1'b0,
            ds_hs, ds_vs, ds_disp, ds_px, ds_py, ds_ls, ds_fs, ds_fc);
    chk_dut("dp", ms, SHA, SHF, SHS, SVA, SVF, SVS, 1'b1,
            dp_hs, dp_vs, dp_disp, dp_px, dp_py, dp_ls, dp_fs, dp_fc);
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      m0 = m_step(m0, DHT, DVT);
      ms = m_step(ms, SHT, SVT);
    end else begin
      m0 = M_RST;
      ms = M_RST;
    end
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous assertion between edges; outputs must clear without a clock.
  task automatic assert_reset_now();
    rst_n = 1'b0;
    m0 = M_RST;
    ms = M_RST;
    #1;
    check_all();
  endtask

  initial begin
    int h_low, ls_cnt, ls_at, v_low, fs_cnt, fs_in_rst, budget, found, nrst;

    m0 = M_RST;
    ms = M_RST;
    rst_n = 1'b0;
    @(negedge clk);
    check_all();
    repeat (3) tick();

    // Release and first edge: counting starts from pix_x=1 with display on.
    rst_n = 1'b1;
    tick();
    chk("first_edge_pix_x", 32'(d0_px), 32'd1);
    chk("first_edge_display_on", 32'(d0_disp), 32'd1);

    // First full 640x480 line.
    h_low = 0; ls_cnt = 0; ls_at = 0;
    for (int i = 2; i <= 800; i++) begin
      tick();
      if (d0_hs == 1'b0) h_low++;
      if (d0_ls) begin
        ls_cnt++;
        ls_at = i;
      end
    end
    chk("line0_hsync_low_clks", 32'(h_low), 32'd96);
    chk("line0_line_start_count", 32'(ls_cnt), 32'd1);
    chk("line0_line_start_clk", 32'(ls_at), 32'd800);

    // Fresh start, then 256 reduced frames.
    @(negedge clk);
    assert_reset_now();
    tick();
    rst_n = 1'b1;
    v_low = 0; fs_cnt = 0;
    for (int c = 1; c <= 256 * SFRAME + 500 && fs_cnt < 256; c++) begin
      tick();
      if (fs_cnt == 0 && ds_vs == 1'b0) v_low++;
      if (ds_fs) begin
        fs_cnt++;
        if (fs_cnt == 1) begin
          chk("frame1_clk", 32'(c), 32'(SFRAME));
          chk("frame1_vsync_low_clks", 32'(v_low), 32'(SVS * SHT));
          chk("frame1_frame_count", 32'(ds_fc), 32'd1);
        end
        if (fs_cnt == 256) chk("frame256_count_wrap", 32'(ds_fc), 32'd0);
      end
    end
    chk("frames_seen", 32'(fs_cnt), 32'd256);

    // Mid-frame reset at a known raster position, held 3 clocks.
    found = 0;
    for (budget = 0; budget < 2 * SFRAME && found == 0; budget++) begin
      tick();
      if (ds_px == 10'd3 && ds_py == 10'd2) found = 1;
    end
    chk("midframe_position_reached", 32'(found), 32'd1);
    assert_reset_now();
    chk("midframe_rst_pix_x", 32'(ds_px), 32'd0);
    chk("midframe_rst_frame_count", 32'(ds_fc), 32'd0);
    fs_in_rst = 0;
    repeat (3) begin
      tick();
      if (ds_fs || d0_fs) fs_in_rst++;
    end
    chk("midframe_no_frame_start", 32'(fs_in_rst), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("midframe_restart_pix_x", 32'(ds_px), 32'd1);
    chk("midframe_restart_display_on", 32'(ds_disp), 32'd1);

    // Random run lengths and reset pulse widths.
    for (int r = 0; r < 6; r++) begin
      nrst = $urandom_range(400, 1);
      repeat (nrst) tick();
      assert_reset_now();
      repeat ($urandom_range(3, 1)) tick();
      rst_n = 1'b1;
      tick();
      chk("rand_restart_pix_x", 32'(d0_px), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
